// File: rtl/ram_pkg.sv
// Shared constants and helpers for the simple dual-port byte-enable RAM.
package ram_pkg;

   localparam int RDW_OLD_DATA = 0;
   localparam int RDW_NEW_DATA = 1;

   function automatic int byte_lanes(input int data_width, input int byte_width);
      return data_width / byte_width;
   endfunction

endpackage

// File: rtl/ram_sdp_lane.sv
// One byte-lane slice of the simple dual-port RAM: memory array, lane write and
// registered read with optional same-address bypass of the incoming write data.
module ram_sdp_lane
   import ram_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 10,
   parameter int BYTE_WIDTH    = 8,
   parameter int RDW_MODE      = RDW_OLD_DATA
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     WriteEnable_i,
   input  logic [ADDRESS_WIDTH-1:0] WriteAddress_i,
   input  logic [BYTE_WIDTH-1:0]    WriteData_i,
   input  logic                     ReadEnable_i,
   input  logic [ADDRESS_WIDTH-1:0] ReadAddress_i,
   output logic [BYTE_WIDTH-1:0]    ReadData_o
);

   localparam int DEPTH = 2 ** ADDRESS_WIDTH;

   logic [BYTE_WIDTH-1:0] mem [DEPTH] = '{default: '0};
   logic [BYTE_WIDTH-1:0] rd_data_p0;
   logic                  collide;

   assign collide = WriteEnable_i && (WriteAddress_i == ReadAddress_i);

   always_ff @(posedge Clock) begin
      if (!Reset && WriteEnable_i) begin
         mem[WriteAddress_i] <= WriteData_i;
      end
   end

   // stage p0: array read register
   always_ff @(posedge Clock) begin
      if (Reset) begin
         rd_data_p0 <= '0;
      end else if (ReadEnable_i) begin
         if (RDW_MODE == RDW_NEW_DATA && collide) begin
            rd_data_p0 <= WriteData_i;
         end else begin
            rd_data_p0 <= mem[ReadAddress_i];
         end
      end
   end

   assign ReadData_o = rd_data_p0;

endmodule

// File: rtl/ram_sdp_byte_enable.sv
// Simple dual-port RAM with per-byte write enables, selectable read-during-write
// policy, optional output register and a read-valid strobe matching the latency.
module ram_sdp_byte_enable
   import ram_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 10,
   parameter int DATA_WIDTH    = 32,
   parameter int BYTE_WIDTH    = 8,
   parameter int OUTPUT_REG    = 1,
   parameter int RDW_MODE      = RDW_OLD_DATA
) (
   input  logic                                Clock,
   input  logic                                Reset,
   input  logic                                WriteEnable_i,
   input  logic [ADDRESS_WIDTH-1:0]            WriteAddress_i,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    WriteByteEnable_i,
   input  logic [DATA_WIDTH-1:0]               WriteData_i,
   input  logic                                ReadEnable_i,
   input  logic [ADDRESS_WIDTH-1:0]            ReadAddress_i,
   output logic [DATA_WIDTH-1:0]               ReadData_o,
   output logic                                ReadValid_o
);

   localparam int LANES = byte_lanes(DATA_WIDTH, BYTE_WIDTH);

   if ((DATA_WIDTH % BYTE_WIDTH) != 0 || RDW_MODE > 1) begin : g_param_check
      $error("ram_sdp_byte_enable: DATA_WIDTH must be a multiple of BYTE_WIDTH and RDW_MODE must be 0 or 1");
   end

   logic [DATA_WIDTH-1:0] rd_data_p0;
   logic                  vld_p0;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      ram_sdp_lane #(
         .ADDRESS_WIDTH (ADDRESS_WIDTH),
         .BYTE_WIDTH    (BYTE_WIDTH),
         .RDW_MODE      (RDW_MODE)
      ) u_lane (
         .Clock          (Clock),
         .Reset          (Reset),
         .WriteEnable_i  (WriteEnable_i && WriteByteEnable_i[k]),
         .WriteAddress_i (WriteAddress_i),
         .WriteData_i    (WriteData_i[k*BYTE_WIDTH +: BYTE_WIDTH]),
         .ReadEnable_i   (ReadEnable_i),
         .ReadAddress_i  (ReadAddress_i),
         .ReadData_o     (rd_data_p0[k*BYTE_WIDTH +: BYTE_WIDTH])
      );
   end

   // stage p0: valid travelling with the lane read registers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         vld_p0 <= 1'b0;
      end else begin
         vld_p0 <= ReadEnable_i;
      end
   end

   if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] rd_data_p1;
      logic                  vld_p1;

      // stage p1: output register, loads only on a valid p0 result
      always_ff @(posedge Clock) begin
         if (Reset) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
         end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
               rd_data_p1 <= rd_data_p0;
            end
         end
      end

      assign ReadData_o  = rd_data_p1;
      assign ReadValid_o = vld_p1;
   end else begin : g_no_oreg
      assign ReadData_o  = rd_data_p0;
      assign ReadValid_o = vld_p0;
   end

endmodule

// File: tb/tb_ram_sdp_byte_enable.sv
// Directed bench: two instances share stimulus, one with defaults (latency 2,
// old-data collisions) and one with no output register and new-data collisions.
module tb_ram_sdp_byte_enable;

   logic        Clock;
   logic        Reset;
   logic        we;
   logic [9:0]  waddr;
   logic [3:0]  wbe;
   logic [31:0] wdata;
   logic        re;
   logic [9:0]  raddr;
   logic [31:0] rd_a, rd_b;
   logic        rv_a, rv_b;

   int n_checks = 0;
   int n_fail   = 0;

   ram_sdp_byte_enable dut_a (
      .Clock             (Clock),
      .Reset             (Reset),
      .WriteEnable_i     (we),
      .WriteAddress_i    (waddr),
      .WriteByteEnable_i (wbe),
      .WriteData_i       (wdata),
      .ReadEnable_i      (re),
      .ReadAddress_i     (raddr),
      .ReadData_o        (rd_a),
      .ReadValid_o       (rv_a)
   );

   ram_sdp_byte_enable #(
      .OUTPUT_REG (0),
      .RDW_MODE   (1)
   ) dut_b (
      .Clock             (Clock),
      .Reset             (Reset),
      .WriteEnable_i     (we),
      .WriteAddress_i    (waddr),
      .WriteByteEnable_i (wbe),
      .WriteData_i       (wdata),
      .ReadEnable_i      (re),
      .ReadAddress_i     (raddr),
      .ReadData_o        (rd_b),
      .ReadValid_o       (rv_b)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge Clock);
      #1;
   endtask

   task automatic write_word(input logic [9:0] a, input logic [3:0] m, input logic [31:0] d);
      we = 1'b1; waddr = a; wbe = m; wdata = d;
      cycle();
      we = 1'b0; wbe = 4'h0;
   endtask

   // Single isolated read: dut_b answers after one edge, dut_a after two.
   task automatic read_check(input string tag, input logic [9:0] a,
                             input logic [31:0] exp_a, input logic [31:0] exp_b);
      re = 1'b1; raddr = a;
      cycle();
      re = 1'b0;
      check({tag, "_b_data"}, rd_b, exp_b);
      check({tag, "_b_vld"},  {31'd0, rv_b}, 32'd1);
      check({tag, "_a_vld_early"}, {31'd0, rv_a}, 32'd0);
      cycle();
      check({tag, "_a_data"}, rd_a, exp_a);
      check({tag, "_a_vld"},  {31'd0, rv_a}, 32'd1);
      check({tag, "_b_vld_drop"}, {31'd0, rv_b}, 32'd0);
      cycle();
      check({tag, "_a_vld_drop"}, {31'd0, rv_a}, 32'd0);
   endtask

   initial begin
      // Test 1: reset held with reads and a write presented
      Reset = 1'b1; re = 1'b1; raddr = 10'd5;
      we = 1'b1; waddr = 10'd5; wbe = 4'hF; wdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("rst_a_data", rd_a, 32'h0);
         check("rst_a_vld",  {31'd0, rv_a}, 32'd0);
         check("rst_b_data", rd_b, 32'h0);
         check("rst_b_vld",  {31'd0, rv_b}, 32'd0);
      end
      Reset = 1'b0; we = 1'b0; wbe = 4'h0; re = 1'b0;
      read_check("post_rst_addr5", 10'd5, 32'h0, 32'h0);

      // Test 2: byte-masked merge and all-zero mask no-op
      write_word(10'd3, 4'b1111, 32'hDEAD_BEEF);
      write_word(10'd3, 4'b0101, 32'h1122_3344);
      write_word(10'd3, 4'b0000, 32'h0000_0000);
      read_check("mask_merge", 10'd3, 32'hDE22_BE44, 32'hDE22_BE44);

      // Test 3: back-to-back reads then hold
      write_word(10'd0, 4'hF, 32'hA0);
      write_word(10'd1, 4'hF, 32'hA1);
      write_word(10'd2, 4'hF, 32'hA2);
      re = 1'b1; raddr = 10'd0;
      cycle();
      check("b2b_e1_b", rd_b, 32'hA0);
      check("b2b_e1_bv", {31'd0, rv_b}, 32'd1);
      check("b2b_e1_av", {31'd0, rv_a}, 32'd0);
      raddr = 10'd1;
      cycle();
      check("b2b_e2_b", rd_b, 32'hA1);
      check("b2b_e2_a", rd_a, 32'hA0);
      check("b2b_e2_av", {31'd0, rv_a}, 32'd1);
      raddr = 10'd2;
      cycle();
      check("b2b_e3_b", rd_b, 32'hA2);
      check("b2b_e3_a", rd_a, 32'hA1);
      check("b2b_e3_av", {31'd0, rv_a}, 32'd1);
      re = 1'b0;
      cycle();
      check("b2b_e4_b_hold", rd_b, 32'hA2);
      check("b2b_e4_bv", {31'd0, rv_b}, 32'd0);
      check("b2b_e4_a", rd_a, 32'hA2);
      check("b2b_e4_av", {31'd0, rv_a}, 32'd1);
      cycle();
      check("b2b_e5_a_hold", rd_a, 32'hA2);
      check("b2b_e5_av", {31'd0, rv_a}, 32'd0);

      // Test 4: same-address collision, old data (dut_a) vs new data (dut_b)
      write_word(10'd7, 4'hF, 32'h1234_5678);
      we = 1'b1; waddr = 10'd7; wbe = 4'b0011; wdata = 32'hCAFE_F00D;
      re = 1'b1; raddr = 10'd7;
      cycle();
      we = 1'b0; wbe = 4'h0; re = 1'b0;
      check("rdw_new_b", rd_b, 32'h1234_F00D);
      check("rdw_new_bv", {31'd0, rv_b}, 32'd1);
      cycle();
      check("rdw_old_a", rd_a, 32'h1234_5678);
      check("rdw_old_av", {31'd0, rv_a}, 32'd1);
      cycle();
      read_check("rdw_after", 10'd7, 32'h1234_F00D, 32'h1234_F00D);

      // Test 5: top address with a concurrent write to a neighbour
      write_word(10'd1023, 4'hF, 32'h55AA_55AA);
      we = 1'b1; waddr = 10'd1022; wbe = 4'hF; wdata = 32'hFFFF_FFFF;
      re = 1'b1; raddr = 10'd1023;
      cycle();
      we = 1'b0; wbe = 4'h0; re = 1'b0;
      check("top_addr_b", rd_b, 32'h55AA_55AA);
      check("top_addr_bv", {31'd0, rv_b}, 32'd1);
      cycle();
      check("top_addr_a", rd_a, 32'h55AA_55AA);
      cycle();
      read_check("neighbour", 10'd1022, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Test 6: reset right after a read request drops it
      re = 1'b1; raddr = 10'd3;
      cycle();
      re = 1'b0; Reset = 1'b1;
      cycle();
      check("rst_drop_av", {31'd0, rv_a}, 32'd0);
      check("rst_drop_a", rd_a, 32'h0);
      check("rst_drop_b", rd_b, 32'h0);
      Reset = 1'b0;
      cycle();
      check("rst_drop_av2", {31'd0, rv_a}, 32'd0);
      check("rst_drop_a2", rd_a, 32'h0);
      read_check("reread", 10'd3, 32'hDE22_BE44, 32'hDE22_BE44);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
